// File: rtl/spi_master_xfer_if.sv
// rtl/spi_master_xfer_if.sv - request/response bundle between the SPI encoder and the transaction engine
interface spi_master_xfer_if;
    logic        tx_req;
    logic [7:0]  tx_addr;
    logic [1:0]  tx_count;
    logic        tx_ack;
    logic        busy;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic [1:0]  rx_count;

    modport master (
        output tx_req, tx_addr, tx_count,
        input  tx_ack, busy, rx_data, rx_valid, rx_count
    );

    modport slave (
        input  tx_req, tx_addr, tx_count,
        output tx_ack, busy, rx_data, rx_valid, rx_count
    );
endinterface

// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - mode-0 SPI engine: one address byte out, up to three read bytes back
module spi_master_xfer #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_xfer_if.slave   host,
    output logic               spi_sclk,
    output logic               spi_cs_n,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_CS_HOLD  = 3'd3;
    localparam logic [2:0] S_CS_GAP   = 3'd4;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_HALF_BIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_INACTIVE_CLKS - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [4:0]  bit_cnt;
    logic [7:0]  tx_sh;
    logic [23:0] rx_sh;
    logic [1:0]  count;
    logic        tx_ack;
    logic        busy;
    logic        rx_valid;
    logic [23:0] rx_data;
    logic [1:0]  rx_count;
    logic        last_bit;

    // Last bit index of the transaction is 8*(1+count)-1
    assign last_bit = (bit_cnt == {count, 3'b111});

    assign host.tx_ack   = tx_ack;
    assign host.busy     = busy;
    assign host.rx_valid = rx_valid;
    assign host.rx_data  = rx_data;
    assign host.rx_count = rx_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            count    <= '0;
            tx_ack   <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_count <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.tx_req) begin
                        tx_sh    <= host.tx_addr;
                        count    <= host.tx_count;
                        tx_ack   <= 1'b1;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= host.tx_addr[7];
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        rx_sh    <= '0;
                        state    <= S_CS_SETUP;
                    end
                end
                S_CS_SETUP: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            // Address-phase MISO is ignored so rx_sh stays right-justified
                            if (bit_cnt >= 5'd8)
                                rx_sh <= {rx_sh[22:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (last_bit) begin
                                spi_mosi <= 1'b0;
                                state    <= S_CS_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 5'd1;
                                spi_mosi <= tx_sh[6];
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                end
                S_CS_HOLD: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        spi_cs_n <= 1'b1;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                        rx_count <= count;
                        state    <= S_CS_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CS_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb/tb_spi_master_xfer.sv - self-checking bench for spi_master_xfer with a mode-0 SPI slave model
module tb_spi_master_xfer;

    logic clk;
    logic rst_n;
    logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;

    spi_master_xfer_if bus ();

    spi_master_xfer #(.CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (bus.slave),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [1:0]  cnt;
        logic [23:0] miso;
        logic [23:0] exp_data;
        int          exp_rises;
        int          exp_cs_low;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [25:0] exp_q[$];
    logic [25:0] act_q[$];
    logic [25:0] model_q[$];

    // Slave model state
    int          rises = 0;
    logic [7:0]  mosi_addr = '0;
    int          tail_ones = 0;
    int          mn = 0;
    logic [23:0] mb = '0;

    // Monitor state
    int   ack_cnt = 0, valid_cnt = 0, ack_busy = 0, mosi_bad = 0;
    int   cs_low_cnt = 0, cs_high_cnt = 0, last_cs_low = 0, last_gap = 0;
    logic busy_prev = 1'b0, sclk_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;

    always @* begin
        if (rises >= 8 && rises < 8 + 8 * mn)
            spi_miso = mb[8 * mn - 1 - (rises - 8)];
        else
            spi_miso = 1'b1;
    end

    always @(posedge spi_sclk or negedge spi_cs_n) begin
        logic [25:0] m;
        if (spi_sclk) begin
            if (rises < 8) mosi_addr = {mosi_addr[6:0], spi_mosi};
            else tail_ones += int'(spi_mosi);
            rises++;
        end else begin
            rises = 0;
            mosi_addr = '0;
            tail_ones = 0;
            if (model_q.size() > 0) begin
                m = model_q.pop_front();
                mn = int'(m[25:24]);
                mb = m[23:0];
            end else begin
                mn = 0;
                mb = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.tx_ack) begin
            ack_cnt++;
            if (busy_prev) ack_busy++;
        end
        if (bus.rx_valid) begin
            valid_cnt++;
            act_q.push_back({bus.rx_count, bus.rx_data});
        end
        if (!spi_cs_n) begin
            if (cs_prev) begin last_gap = cs_high_cnt; cs_high_cnt = 0; end
            cs_low_cnt++;
        end else begin
            if (!cs_prev) begin last_cs_low = cs_low_cnt; cs_low_cnt = 0; end
            cs_high_cnt++;
        end
        if (rst_n && spi_mosi != mosi_prev && !(sclk_prev && !spi_sclk) && cs_prev == spi_cs_n)
            mosi_bad++;
        busy_prev = bus.busy;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
        mosi_prev = spi_mosi;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [1:0] c, input logic [23:0] m,
                         input logic [23:0] e);
        bus.tx_addr  = a;
        bus.tx_count = c;
        bus.tx_req   = 1'b1;
        exp_q.push_back({c, e});
        model_q.push_back({c, m});
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.tx_ack) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic check_result(input string nm);
        logic [25:0] e, a;
        if (act_q.size() == 0 || exp_q.size() == 0) begin
            chk({nm, "_result_present"}, 32'(act_q.size()), 32'(exp_q.size()));
        end else begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            chk({nm, "_rx_data"}, {8'h0, a[23:0]}, {8'h0, e[23:0]});
            chk({nm, "_rx_count"}, {30'h0, a[25:24]}, {30'h0, e[25:24]});
        end
    endtask

    task automatic check_txn(input string nm, input vec_t v, input int a0, input int v0);
        check_result(nm);
        chk({nm, "_sclk_rises"}, 32'(rises), 32'(v.exp_rises));
        chk({nm, "_mosi_addr"}, {24'h0, mosi_addr}, {24'h0, v.addr});
        chk({nm, "_mosi_tail_ones"}, 32'(tail_ones), 32'd0);
        chk({nm, "_cs_low_clks"}, 32'(last_cs_low), 32'(v.exp_cs_low));
        chk({nm, "_tx_ack_count"}, 32'(ack_cnt - a0), 32'd1);
        chk({nm, "_rx_valid_count"}, 32'(valid_cnt - v0), 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        bit ok;
        int a0, v0;
        vec_t v;

        vecs[0] = '{8'hA4, 2'd2, 24'h001234, 24'h001234, 24, 100};
        vecs[1] = '{8'hA8, 2'd0, 24'h000000, 24'h000000, 8, 36};
        vecs[2] = '{8'h3C, 2'd3, 24'hABCDEF, 24'hABCDEF, 32, 132};
        vecs[3] = '{8'h81, 2'd1, 24'hFFFF5A, 24'h00005A, 16, 68};

        bus.tx_req = 1'b0;
        bus.tx_addr = '0;
        bus.tx_count = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("reset_cs_n", {31'h0, spi_cs_n}, 32'd1);
        chk("reset_sclk", {31'h0, spi_sclk}, 32'd0);
        chk("reset_mosi", {31'h0, spi_mosi}, 32'd0);
        chk("reset_busy", {31'h0, bus.busy}, 32'd0);
        chk("reset_tx_ack", {31'h0, bus.tx_ack}, 32'd0);
        chk("reset_rx_valid", {31'h0, bus.rx_valid}, 32'd0);
        chk("reset_rx_data", {8'h0, bus.rx_data}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            v  = vecs[i];
            a0 = ack_cnt;
            v0 = valid_cnt;
            drive(v.addr, v.cnt, v.miso, v.exp_data);
            wait_ack(ok);
            chk($sformatf("vec%0d_ack_seen", i), {31'h0, ok}, 32'd1);
            bus.tx_req = 1'b0;
            wait_idle(ok);
            chk($sformatf("vec%0d_idle_seen", i), {31'h0, ok}, 32'd1);
            check_txn($sformatf("vec%0d", i), v, a0, v0);
        end

        // Held tx_req across two back-to-back transactions
        drive(8'hA4, 2'd1, 24'h000077, 24'h000077);
        wait_ack(ok);
        chk("held_ack1", {31'h0, ok}, 32'd1);
        drive(8'hA8, 2'd3, 24'hABCDEF, 24'hABCDEF);
        wait_ack(ok);
        chk("held_ack2", {31'h0, ok}, 32'd1);
        @(negedge clk);
        bus.tx_req = 1'b0;
        chk("held_cs_gap_ge2", {31'h0, last_gap >= 2}, 32'd1);
        chk("held_ack_while_busy", 32'(ack_busy), 32'd0);
        wait_idle(ok);
        check_result("held_first");
        check_result("held_second");

        // Request pulse with a new address during SHIFT must be ignored
        a0 = ack_cnt;
        v0 = valid_cnt;
        drive(8'hA4, 2'd2, 24'h001234, 24'h001234);
        wait_ack(ok);
        bus.tx_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rises >= 10) begin ok = 1'b1; break; end
        end
        chk("busy_req_reach_shift", {31'h0, ok}, 32'd1);
        bus.tx_addr = 8'hFF;
        bus.tx_req  = 1'b1;
        @(negedge clk);
        bus.tx_req  = 1'b0;
        wait_idle(ok);
        check_txn("busy_req", vecs[0], a0, v0);

        // Asynchronous reset in the middle of the address byte
        v0 = valid_cnt;
        drive(8'hA8, 2'd2, 24'h00BEEF, 24'h00BEEF);
        wait_ack(ok);
        bus.tx_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rises == 5) begin ok = 1'b1; break; end
        end
        chk("rst_reach_bit5", {31'h0, ok}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_cs_n", {31'h0, spi_cs_n}, 32'd1);
        chk("rst_async_sclk", {31'h0, spi_sclk}, 32'd0);
        chk("rst_async_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_rx_data_cleared", {8'h0, bus.rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_rx_valid", 32'(valid_cnt - v0), 32'd0);
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        @(negedge clk);
        a0 = ack_cnt;
        v0 = valid_cnt;
        v = '{8'hA8, 2'd1, 24'h00005A, 24'h00005A, 16, 68};
        drive(v.addr, v.cnt, v.miso, v.exp_data);
        wait_ack(ok);
        chk("post_rst_ack_seen", {31'h0, ok}, 32'd1);
        bus.tx_req = 1'b0;
        wait_idle(ok);
        check_txn("post_rst", v, a0, v0);

        chk("mosi_changed_off_fall", 32'(mosi_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
